arb_rr_2ch: RTL

- Two-channel, packet-level round-robin arbiter with valid/ready handshakes and a registered output stage.
- Sits directly upstream of the 2:1 select stage and generates its select line `sel`.
- Merges two packetised data streams onto one output channel.
- A granted channel keeps ownership until its last beat is accepted.

---
 rtl/arb_rr_2ch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/arb_rr_2ch.sv
// arb_rr_2ch: two-channel, packet-level round-robin arbiter.
//
// Merges two packetised valid/ready streams onto one registered output
// channel. A granted channel keeps ownership until its last beat is accepted.
// After each packet, one IDLE cycle is spent arbitrating. If both channels
// request at that point, the channel that did not send the previous packet
// wins.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   in0_valid/in0_data/in0_last      channel 0 beat in
//   in0_ready                        channel 0 accept (combinational)
//   in1_valid/in1_data/in1_last      channel 1 beat in
//   in1_ready                        channel 1 accept (combinational)
//   out_valid/out_data/out_last      registered output beat
//   out_ready                        downstream accept
//   sel                              registered grant, drives the 2:1 select
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | between packets; arbitrate, accept nothing
// S_GNT0  | channel 0 owns the output until its last beat is accepted
// S_GNT1  | channel 1 owns the output until its last beat is accepted
module arb_rr_2ch #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          sel
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          sel_q, sel_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic out_free;
  logic acc0, acc1;

  // The output register can take a new beat when it is empty or being drained
  // in the same cycle, which gives back-to-back beats with no bubble.
  assign out_free  = !out_valid_q || out_ready;
  assign in0_ready = (state_q == S_GNT0) && out_free;
  assign in1_ready = (state_q == S_GNT1) && out_free;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    unique case (state_q)
      S_IDLE: begin
        // On a tie, channel 0 wins only if channel 1 sent the last packet.
        if (in0_valid && (!in1_valid || last_grant_q)) begin
          state_d = S_GNT0;
          sel_d   = 1'b0;
        end else if (in1_valid) begin
          state_d = S_GNT1;
          sel_d   = 1'b1;
        end
      end
      S_GNT0: begin
        if (acc0 && in0_last) begin
          state_d      = S_IDLE;
          last_grant_d = 1'b0;
        end
      end
      S_GNT1: begin
        if (acc1 && in1_last) begin
          state_d      = S_IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (acc0) begin
      out_valid_d = 1'b1;
      out_data_d  = in0_data;
      out_last_d  = in0_last;
    end else if (acc1) begin
      out_valid_d = 1'b1;
      out_data_d  = in1_data;
      out_last_d  = in1_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;

endmodule
